// File: rtl/bram_ctrl_pkg.sv
// Shared state type, read latency and helpers for the BRAM line controller.
// Define BRAM_LINE_CTRL_HIGH_PERF_EN for a BRAM with an output register (LAT=2).
package bram_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } ctrl_state_e;

`ifdef BRAM_LINE_CTRL_HIGH_PERF_EN
    localparam int LAT       = 2;
    localparam bit HIGH_PERF = 1'b1;
`else
    localparam int LAT       = 1;
    localparam bit HIGH_PERF = 1'b0;
`endif

    function automatic int ctrl_clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// Read-return tracker: a LAT-deep shift of issue/last markers aligned with ram_douta.
// Depth follows BRAM_LINE_CTRL_HIGH_PERF_EN through bram_ctrl_pkg::LAT.
module bram_rd_pipe
    import bram_ctrl_pkg::*;
#(
    parameter int DEPTH = LAT
) (
    input  logic clka,
    input  logic rsta,
    input  logic issue,
    input  logic issue_last,
    output logic rd_valid,
    output logic rd_last,
    output logic drained,
    output logic regce
);

    localparam logic [DEPTH-1:0] OUT_BIT = DEPTH'(1'b1) << (DEPTH - 1);

    logic [DEPTH-1:0] vld_r;
    logic [DEPTH-1:0] last_r;

    // Advance issue markers one stage per cycle toward the output stage
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            vld_r  <= {DEPTH{1'b0}};
            last_r <= {DEPTH{1'b0}};
        end else begin
            vld_r  <= (vld_r << 1) | DEPTH'(issue);
            last_r <= (last_r << 1) | DEPTH'(issue && issue_last);
        end
    end

    assign rd_valid = vld_r[DEPTH-1];
    assign rd_last  = last_r[DEPTH-1];
    // Nothing behind the output stage: the pipe is empty after this cycle
    assign drained  = ((vld_r & ~OUT_BIT) == {DEPTH{1'b0}});
    assign regce    = HIGH_PERF ? (|vld_r) : 1'b0;

endmodule

// File: rtl/bram_line_ctrl.sv
// Line-burst controller for a no-change single-port BRAM: whole-line writes and reads.
// Define BRAM_LINE_CTRL_HIGH_PERF_EN to use the BRAM output register (two-cycle reads).
module bram_line_ctrl
    import bram_ctrl_pkg::*;
#(
    parameter int RAM_WIDTH  = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int LINE_WORDS = 8
) (
    input  logic                                         clka,
    input  logic                                         rsta,
    input  logic                                         req_valid,
    output logic                                         req_ready,
    input  logic                                         req_we,
    input  logic [ADDR_WIDTH-ctrl_clog2(LINE_WORDS)-1:0] req_line,
    input  logic                                         wdata_valid,
    output logic                                         wdata_ready,
    input  logic [RAM_WIDTH-1:0]                         wdata,
    output logic                                         rdata_valid,
    output logic [RAM_WIDTH-1:0]                         rdata,
    output logic                                         rdata_last,
    output logic                                         done,
    output logic [ADDR_WIDTH-1:0]                        ram_addra,
    output logic [RAM_WIDTH-1:0]                         ram_dina,
    output logic                                         ram_wea,
    output logic                                         ram_ena,
    output logic                                         ram_regcea,
    input  logic [RAM_WIDTH-1:0]                         ram_douta
);

    localparam int OFS_W  = ctrl_clog2(LINE_WORDS);
    localparam int LINE_W = ADDR_WIDTH - OFS_W;
    localparam logic [OFS_W-1:0] OFS_MAX = OFS_W'(LINE_WORDS - 1);

    ctrl_state_e          state_r;
    logic [LINE_W-1:0]    line_r;
    logic [OFS_W-1:0]     ofs_r;
    logic                 req_ready_r;
    logic                 wdata_ready_r;
    logic                 done_r;
    logic [ADDR_WIDTH-1:0] addr_hold_r;
    logic [RAM_WIDTH-1:0] dina_hold_r;

    logic wr_beat_s;
    logic rd_issue_s;
    logic access_s;
    logic pipe_drained_s;

    assign wr_beat_s  = (state_r == ST_WRITE) && wdata_valid;
    assign rd_issue_s = (state_r == ST_READ);
    assign access_s   = wr_beat_s || rd_issue_s;

    // Line sequencing with registered handshake and completion outputs
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state_r       <= ST_IDLE;
            line_r        <= {LINE_W{1'b0}};
            ofs_r         <= {OFS_W{1'b0}};
            req_ready_r   <= 1'b1;
            wdata_ready_r <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (req_valid && req_ready_r) begin
                        line_r      <= req_line;
                        ofs_r       <= {OFS_W{1'b0}};
                        req_ready_r <= 1'b0;
                        if (req_we) begin
                            state_r       <= ST_WRITE;
                            wdata_ready_r <= 1'b1;
                        end else begin
                            state_r       <= ST_READ;
                            wdata_ready_r <= 1'b0;
                        end
                    end else begin
                        req_ready_r   <= 1'b1;
                        wdata_ready_r <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (wdata_valid) begin
                        ofs_r <= ofs_r + OFS_W'(1'b1);
                        if (ofs_r == OFS_MAX) begin
                            state_r       <= ST_DONE;
                            wdata_ready_r <= 1'b0;
                            done_r        <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    ofs_r <= ofs_r + OFS_W'(1'b1);
                    if (ofs_r == OFS_MAX) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pipe_drained_s) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r     <= ST_IDLE;
                    done_r      <= 1'b0;
                    req_ready_r <= 1'b1;
                end
                default: begin
                    state_r       <= ST_IDLE;
                    req_ready_r   <= 1'b1;
                    wdata_ready_r <= 1'b0;
                    done_r        <= 1'b0;
                end
            endcase
        end
    end

    // Remember the last address/data presented so idle cycles do not disturb the port
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            addr_hold_r <= {ADDR_WIDTH{1'b0}};
            dina_hold_r <= {RAM_WIDTH{1'b0}};
        end else begin
            if (access_s) begin
                addr_hold_r <= {line_r, ofs_r};
            end
            if (wr_beat_s) begin
                dina_hold_r <= wdata;
            end
        end
    end

    assign ram_ena   = access_s;
    assign ram_wea   = wr_beat_s;
    assign ram_addra = access_s ? {line_r, ofs_r} : addr_hold_r;
    assign ram_dina  = wr_beat_s ? wdata : dina_hold_r;

    bram_rd_pipe #(
        .DEPTH(LAT)
    ) u_rd_pipe (
        .clka       (clka),
        .rsta       (rsta),
        .issue      (rd_issue_s),
        .issue_last (ofs_r == OFS_MAX),
        .rd_valid   (rdata_valid),
        .rd_last    (rdata_last),
        .drained    (pipe_drained_s),
        .regce      (ram_regcea)
    );

    assign rdata       = ram_douta;
    assign req_ready   = req_ready_r;
    assign wdata_ready = wdata_ready_r;
    assign done        = done_r;

endmodule

// File: tb/tb_bram_line_ctrl.sv
// Bench for bram_line_ctrl: vector table of line transfers, reset/backpressure sequences,
// and random traffic checked against a word-array model of the intended BRAM contents.
module tb_bram_line_ctrl;

    localparam int RAM_WIDTH  = 32;
    localparam int ADDR_WIDTH = 9;
    localparam int LINE_WORDS = 8;
    localparam int LINE_W     = 6;
    localparam int LINES      = 64;
    localparam int NVEC       = 8;
`ifdef BRAM_LINE_CTRL_HIGH_PERF_EN
    localparam int TB_LAT = 2;
`else
    localparam int TB_LAT = 1;
`endif

    logic                  clka = 1'b0;
    logic                  rsta;
    logic                  req_valid, req_ready, req_we;
    logic [LINE_W-1:0]     req_line;
    logic                  wdata_valid, wdata_ready;
    logic [RAM_WIDTH-1:0]  wdata, rdata, ram_dina, ram_douta;
    logic                  rdata_valid, rdata_last, done;
    logic [ADDR_WIDTH-1:0] ram_addra;
    logic                  ram_wea, ram_ena, ram_regcea;

    bram_line_ctrl #(
        .RAM_WIDTH (RAM_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .LINE_WORDS(LINE_WORDS)
    ) dut (
        .clka       (clka),
        .rsta       (rsta),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_line   (req_line),
        .wdata_valid(wdata_valid),
        .wdata_ready(wdata_ready),
        .wdata      (wdata),
        .rdata_valid(rdata_valid),
        .rdata      (rdata),
        .rdata_last (rdata_last),
        .done       (done),
        .ram_addra  (ram_addra),
        .ram_dina   (ram_dina),
        .ram_wea    (ram_wea),
        .ram_ena    (ram_ena),
        .ram_regcea (ram_regcea),
        .ram_douta  (ram_douta)
    );

    always #5 clka = ~clka;

    // No-change single-port BRAM, optional output register
    logic [RAM_WIDTH-1:0] mem [0:511];
    logic [RAM_WIDTH-1:0] dout_latch = 32'h0;
    logic [RAM_WIDTH-1:0] dout_reg   = 32'h0;
    always @(posedge clka) begin
        if (ram_ena) begin
            if (ram_wea) mem[ram_addra] <= ram_dina;
            else         dout_latch     <= mem[ram_addra];
        end
        if (ram_regcea) dout_reg <= dout_latch;
    end
    assign ram_douta = (TB_LAT == 2) ? dout_reg : dout_latch;

    // Reference: what each word should hold after the requests issued so far
    logic [RAM_WIDTH-1:0] ref_mem [0:511];
    bit                   written [0:LINES-1];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // One full line transfer; on entry the bench sits #1 after a clock edge
    task automatic run_line(input logic we, input logic [LINE_W-1:0] line, input logic [31:0] base,
                            input int gap_at, input int gap_len, input int exp_done,
                            input bit hold, input logic hold_we, input logic [LINE_W-1:0] hold_line);
        int k, iss, nrd, gap_cnt, done_at, lbase;
        k = 0; iss = 0; nrd = 0; gap_cnt = 0; done_at = 0;
        lbase = int'(line) * LINE_WORDS;
        @(negedge clka);
        chk("idle_req_ready", req_ready, 1);
        chk("idle_done_low", done, 0);
        req_valid = 1'b1;
        req_we    = we;
        req_line  = line;
        if (we) begin
            for (int i = 0; i < LINE_WORDS; i++) ref_mem[lbase + i] = base + i;
            written[line] = 1'b1;
        end
        @(posedge clka); #1;
        if (hold) begin
            req_we   = hold_we;
            req_line = hold_line;
        end else begin
            req_valid = 1'b0;
        end
        for (int cyc = 1; cyc <= 40 && done_at == 0; cyc++) begin
            wdata_valid = 1'b0;
            wdata       = $urandom;
            if (we && k < LINE_WORDS) begin
                if (k == gap_at && gap_cnt < gap_len) gap_cnt++;
                else begin
                    wdata_valid = 1'b1;
                    wdata       = base + k;
                end
            end
            @(negedge clka);
            chk("busy_req_ready", req_ready, 0);
            if (done) begin
                done_at = cyc;
                chk("done_cycle", cyc, exp_done);
            end
            if (we) begin
                chk("wr_no_rdata", rdata_valid, 0);
                if (wdata_valid) begin
                    chk("wr_ena_wea_rdy", {ram_ena, ram_wea, wdata_ready}, 3'b111);
                    chk("wr_addr", ram_addra, lbase + k);
                    chk("wr_dina", ram_dina, base + k);
                    k++;
                end else if (k < LINE_WORDS) begin
                    chk("gap_idle", {ram_ena, ram_wea, wdata_ready}, 3'b001);
                end else begin
                    chk("post_wr_idle", {ram_ena, ram_wea, wdata_ready}, 3'b000);
                end
            end else begin
                if (ram_ena) begin
                    chk("rd_wea", ram_wea, 0);
                    chk("rd_issue_cycle", cyc, iss + 1);
                    chk("rd_addr", ram_addra, lbase + iss);
                    iss++;
                end
                if (rdata_valid) begin
                    if (nrd == 0) chk("rd_first_cycle", cyc, TB_LAT + 1);
                    chk("rd_data", rdata, ref_mem[lbase + nrd]);
                    chk("rd_last", rdata_last, nrd == LINE_WORDS - 1);
                    nrd++;
                end
                chk("regcea", ram_regcea, (TB_LAT == 2) && cyc >= 2 && cyc <= LINE_WORDS + 2);
            end
            @(posedge clka); #1;
        end
        chk("done_seen", done_at != 0, 1);
        if (we) begin
            chk("wr_beats", k, LINE_WORDS);
            for (int i = 0; i < LINE_WORDS; i++) chk("bram_word", mem[lbase + i], base + i);
        end else begin
            chk("rd_issues", iss, LINE_WORDS);
            chk("rd_words", nrd, LINE_WORDS);
        end
    endtask

    typedef struct {
        logic              we;
        logic [LINE_W-1:0] line;
        logic [31:0]       base;
        int                gap_at;
        int                gap_len;
        bit                hold;
        int                exp_done;
    } vec_t;

    vec_t tbl [NVEC];

    initial begin
        int  ena_cnt;
        bit  hold;
        logic hwe;
        logic [LINE_W-1:0] hl;
        logic rwe;
        logic [LINE_W-1:0] rline;
        int  rgap;

        tbl[0] = '{1'b1, 6'd3,  32'hA0,  -1, 0, 1'b0, 9};
        tbl[1] = '{1'b0, 6'd3,  32'h0,   -1, 0, 1'b0, 9 + TB_LAT};
        tbl[2] = '{1'b1, 6'd5,  32'h50,   4, 3, 1'b0, 12};
        tbl[3] = '{1'b0, 6'd5,  32'h0,   -1, 0, 1'b1, 9 + TB_LAT};
        tbl[4] = '{1'b1, 6'd63, 32'hC0,  -1, 0, 1'b0, 9};
        tbl[5] = '{1'b0, 6'd63, 32'h0,   -1, 0, 1'b0, 9 + TB_LAT};
        tbl[6] = '{1'b1, 6'd0,  32'h10,   0, 2, 1'b0, 11};
        tbl[7] = '{1'b0, 6'd0,  32'h0,   -1, 0, 1'b0, 9 + TB_LAT};

        for (int i = 0; i < LINES; i++) written[i] = 1'b0;
        rsta = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_line = 6'd0;
        wdata_valid = 1'b0; wdata = 32'h0;

        repeat (3) @(posedge clka);
        @(negedge clka);
        chk("rst_outputs", {wdata_ready, rdata_valid, rdata_last, done, ram_ena, ram_wea, ram_regcea}, 7'b0);
        @(posedge clka); #1;
        rsta = 1'b0;
        @(negedge clka);
        chk("rst_req_ready", req_ready, 1);
        @(posedge clka); #1;

        for (int i = 0; i < NVEC; i++) begin
            hold = tbl[i].hold && (i + 1 < NVEC);
            hwe  = 1'b0;
            hl   = 6'd0;
            if (hold) begin
                hwe = tbl[i + 1].we;
                hl  = tbl[i + 1].line;
            end
            run_line(tbl[i].we, tbl[i].line, tbl[i].base, tbl[i].gap_at, tbl[i].gap_len,
                     tbl[i].exp_done, hold, hwe, hl);
        end

        // Reset in the middle of a read of line 3, after four issues
        @(negedge clka);
        req_valid = 1'b1; req_we = 1'b0; req_line = 6'd3;
        @(posedge clka); #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clka);
        #1;
        chk("pre_rst_rdata_valid", rdata_valid, 1);
        rsta = 1'b1;
        #1;
        chk("rst_mid_outputs", {rdata_valid, rdata_last, done, ram_ena, ram_wea, ram_regcea}, 6'b0);
        chk("rst_mid_req_ready", req_ready, 1);
        ena_cnt = 0;
        repeat (2) begin
            @(negedge clka);
            if (ram_ena) ena_cnt++;
        end
        @(posedge clka); #1;
        rsta = 1'b0;
        repeat (3) begin
            @(negedge clka);
            if (ram_ena || rdata_valid) ena_cnt++;
        end
        chk("no_access_after_rst", ena_cnt, 0);
        @(posedge clka); #1;
        run_line(1'b0, 6'd3, 32'h0, -1, 0, 9 + TB_LAT, 1'b0, 1'b0, 6'd0);

        // Random traffic against the reference contents
        for (int t = 0; t < 24; t++) begin
            rwe   = 1'($urandom_range(0, 1));
            rline = 6'($urandom_range(0, LINES - 1));
            if (!written[rline]) rwe = 1'b1;
            rgap  = rwe ? $urandom_range(0, 3) : 0;
            run_line(rwe, rline, $urandom, $urandom_range(0, LINE_WORDS - 1), rgap,
                     rwe ? 9 + rgap : 9 + TB_LAT, 1'b0, 1'b0, 6'd0);
        end

        @(negedge clka);
        chk("final_idle", {req_ready, done, ram_ena}, 3'b100);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
